// File: rtl/axis_uart_tx_arbiter_pkg.sv
// Shared types and constants for the AXI-Stream UART TX arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package axis_uart_tx_arbiter_pkg;

    // Arbiter FSM states: waiting for a request, sending the source-ID header, forwarding payload
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    // Default header constant; the granted source index is OR-ed into the low bits
    localparam int unsigned HDR_BASE_DFLT = 32'h0000_00A0;

endpackage

// File: rtl/axis_uart_tx_arbiter_rr_pick.sv
// Round-robin search: first asserted request at or above ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk the requesters starting at ptr; the first hit wins and later hits are ignored
    always_comb begin
        int cand;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/axis_uart_tx_arbiter.sv
// Packet-level round-robin arbiter merging NUM_SRC AXI-Stream sources toward a UART TX FIFO.
// Latency: one cycle from request to header (or first data beat); payload then passes through combinationally.
// Backpressure: m_axis_ready is forwarded to the granted source only; a stall holds the current beat stable.
module axis_uart_tx_arbiter
    import axis_uart_tx_arbiter_pkg::*;
#(
    parameter int          NUM_SRC  = 4,
    parameter int          WIDTH    = 8,
    parameter bit          HDR_EN   = 1'b1,
    parameter int unsigned HDR_BASE = HDR_BASE_DFLT,
    localparam int         IW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC*WIDTH-1:0] s_axis_data,
    input  logic [NUM_SRC-1:0]       s_axis_valid,
    input  logic [NUM_SRC-1:0]       s_axis_last,
    output logic [NUM_SRC-1:0]       s_axis_ready,
    output logic [WIDTH-1:0]         m_axis_data,
    output logic                     m_axis_valid,
    output logic                     m_axis_last,
    input  logic                     m_axis_ready,
    output logic [IW-1:0]            grant_id,
    output logic                     busy
);

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic [IW-1:0]   grant_nxt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   ptr_nxt;
    logic [IW-1:0]   ptr_inc;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    logic [WIDTH-1:0]    src_dat;
    logic                src_vld;
    logic                src_lst;
    logic [WIDTH+31:0]   hdr_full;
    logic [WIDTH-1:0]    hdr_dat;

    rr_pick #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_rr_pick (
        .req (s_axis_valid),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Granted source's beat, selected by the latched owner
    assign src_dat = s_axis_data[int'(grant_id)*WIDTH +: WIDTH];
    assign src_vld = s_axis_valid[grant_id];
    assign src_lst = s_axis_last[grant_id];

    // Header word is computed wide and then truncated so any WIDTH works
    assign hdr_full = (WIDTH+32)'(HDR_BASE) | (WIDTH+32)'(grant_id);
    assign hdr_dat  = hdr_full[WIDTH-1:0];

    // Next round-robin start is the owner after the current one, wrapping at NUM_SRC
    assign ptr_inc = (int'(grant_id) == NUM_SRC - 1) ? '0 : grant_id + IW'(1);

    // Busy reflects an owned packet; forced low while reset is asserted
    assign busy = (state != ST_IDLE) && !rst;

    // State, owner and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            rr_ptr   <= ptr_nxt;
        end
    end

    // Next-state and output decode; reset forces every output quiet in the same cycle
    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant_id;
        ptr_nxt      = rr_ptr;
        m_axis_data  = '0;
        m_axis_valid = 1'b0;
        m_axis_last  = 1'b0;
        s_axis_ready = '0;
        unique case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_nxt = pick_idx;
                    state_nxt = HDR_EN ? ST_HDR : ST_DATA;
                end
            end
            ST_HDR: begin
                m_axis_data  = hdr_dat;
                m_axis_valid = 1'b1;
                if (m_axis_ready) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                m_axis_data            = src_dat;
                m_axis_valid           = src_vld;
                m_axis_last            = src_lst;
                s_axis_ready[grant_id] = m_axis_ready;
                // Grant is released only on the accepted last beat, never on other sources' activity
                if (src_vld && src_lst && m_axis_ready) begin
                    state_nxt = ST_IDLE;
                    ptr_nxt   = ptr_inc;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (rst) begin
            m_axis_data  = '0;
            m_axis_valid = 1'b0;
            m_axis_last  = 1'b0;
            s_axis_ready = '0;
        end
    end

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Directed self-checking bench for axis_uart_tx_arbiter (header and headerless builds).
// Latency: n/a.
// Backpressure: n/a.
module tb_axis_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_axis_ready;

    // Header-enabled instance
    logic [31:0] s_axis_data;
    logic [3:0]  s_axis_valid;
    logic [3:0]  s_axis_last;
    logic [3:0]  s_axis_ready;
    logic [7:0]  m_axis_data;
    logic        m_axis_valid;
    logic        m_axis_last;
    logic [1:0]  grant_id;
    logic        busy;

    // Headerless instance
    logic [31:0] b_data;
    logic [3:0]  b_valid;
    logic [3:0]  b_last;
    logic [3:0]  b_ready;
    logic [7:0]  bm_data;
    logic        bm_valid;
    logic        bm_last;
    logic [1:0]  b_grant;
    logic        b_busy;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    axis_uart_tx_arbiter #(.NUM_SRC(4), .WIDTH(8), .HDR_EN(1'b1), .HDR_BASE(32'hA0)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_last  (s_axis_last),
        .s_axis_ready (s_axis_ready),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_last  (m_axis_last),
        .m_axis_ready (m_axis_ready),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    axis_uart_tx_arbiter #(.NUM_SRC(4), .WIDTH(8), .HDR_EN(1'b0), .HDR_BASE(32'hA0)) dut_nohdr (
        .clk          (clk),
        .rst          (rst),
        .s_axis_data  (b_data),
        .s_axis_valid (b_valid),
        .s_axis_last  (b_last),
        .s_axis_ready (b_ready),
        .m_axis_data  (bm_data),
        .m_axis_valid (bm_valid),
        .m_axis_last  (bm_last),
        .m_axis_ready (m_axis_ready),
        .grant_id     (b_grant),
        .busy         (b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are then driven and outputs sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic l, input logic [7:0] d);
        s_axis_valid[i]      = v;
        s_axis_last[i]       = l;
        s_axis_data[i*8 +: 8] = d;
    endtask

    task automatic set_b(input int i, input logic v, input logic l, input logic [7:0] d);
        b_valid[i]       = v;
        b_last[i]        = l;
        b_data[i*8 +: 8] = d;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_vld"},  32'(m_axis_valid), 32'd0);
        check({tag, "_last"}, 32'(m_axis_last),  32'd0);
        check({tag, "_dat"},  32'(m_axis_data),  32'd0);
        check({tag, "_rdy"},  32'(s_axis_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy),         32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_beats [5];
        int k;
        int src_idx;
        int cyc;
        logic xfer;

        rst          = 1'b1;
        m_axis_ready = 1'b1;
        s_axis_data  = '0;
        s_axis_valid = '0;
        s_axis_last  = '0;
        b_data       = '0;
        b_valid      = '0;
        b_last       = '0;

        // ---- reset state (during and after)
        tick();
        tick();
        check_quiet("rst_during");
        check("rst_grant", 32'(grant_id), 32'd0);
        rst = 1'b0;
        #1;
        check_quiet("rst_after");

        // ---- single source src1: A1,11,22,33
        set_src(1, 1'b1, 1'b0, 8'h11);
        #1;
        check("s1_idle_vld", 32'(m_axis_valid), 32'd0);
        tick();
        check("s1_hdr_dat",  32'(m_axis_data),  32'hA1);
        check("s1_hdr_vld",  32'(m_axis_valid), 32'd1);
        check("s1_hdr_last", 32'(m_axis_last),  32'd0);
        check("s1_hdr_rdy",  32'(s_axis_ready), 32'h0);
        check("s1_grant",    32'(grant_id),     32'd1);
        check("s1_busy",     32'(busy),         32'd1);
        tick();
        check("s1_b0_dat",  32'(m_axis_data),  32'h11);
        check("s1_b0_last", 32'(m_axis_last),  32'd0);
        check("s1_b0_rdy",  32'(s_axis_ready), 32'h2);
        tick();
        set_src(1, 1'b1, 1'b0, 8'h22);
        #1;
        check("s1_b1_dat", 32'(m_axis_data), 32'h22);
        tick();
        set_src(1, 1'b1, 1'b1, 8'h33);
        #1;
        check("s1_b2_dat",  32'(m_axis_data), 32'h33);
        check("s1_b2_last", 32'(m_axis_last), 32'd1);
        tick();
        set_src(1, 1'b0, 1'b0, 8'h00);
        #1;
        check("s1_end_busy", 32'(busy),         32'd0);
        check("s1_end_vld",  32'(m_axis_valid), 32'd0);

        // ---- contention src0 vs src2 from reset
        do_reset();
        set_src(0, 1'b1, 1'b0, 8'h01);
        set_src(2, 1'b1, 1'b0, 8'h21);
        tick();
        check("ct_hdr0", 32'(m_axis_data), 32'hA0);
        tick();
        check("ct_s0b0", 32'(m_axis_data),  32'h01);
        check("ct_rdy0", 32'(s_axis_ready), 32'h1);
        tick();
        set_src(0, 1'b1, 1'b1, 8'h02);
        #1;
        check("ct_s0b1",   32'(m_axis_data), 32'h02);
        check("ct_s0last", 32'(m_axis_last), 32'd1);
        tick();
        set_src(0, 1'b1, 1'b1, 8'h03);
        #1;
        check("ct_idle_vld", 32'(m_axis_valid), 32'd0);
        tick();
        check("ct_hdr2",  32'(m_axis_data), 32'hA2);
        check("ct_grant2", 32'(grant_id),   32'd2);
        tick();
        check("ct_s2b0", 32'(m_axis_data),  32'h21);
        check("ct_rdy2", 32'(s_axis_ready), 32'h4);
        tick();
        set_src(2, 1'b1, 1'b1, 8'h22);
        #1;
        check("ct_s2b1", 32'(m_axis_data), 32'h22);
        tick();
        set_src(2, 1'b0, 1'b0, 8'h00);
        tick();
        check("ct_hdr0b", 32'(m_axis_data), 32'hA0);
        tick();
        check("ct_s0new", 32'(m_axis_data), 32'h03);
        tick();
        set_src(0, 1'b0, 1'b0, 8'h00);
        #1;
        check("ct_end_busy", 32'(busy), 32'd0);

        // ---- src3 requests during a src1 packet (rr_ptr is 1 here)
        set_src(1, 1'b1, 1'b0, 8'h31);
        tick();
        check("mp_hdr1", 32'(m_axis_data), 32'hA1);
        set_src(3, 1'b1, 1'b1, 8'h3F);
        #1;
        check("mp_rdy_hdr", 32'(s_axis_ready), 32'h0);
        tick();
        check("mp_b0",    32'(m_axis_data),  32'h31);
        check("mp_rdy_b0", 32'(s_axis_ready), 32'h2);
        tick();
        set_src(1, 1'b1, 1'b1, 8'h32);
        #1;
        check("mp_b1",     32'(m_axis_data),  32'h32);
        check("mp_grant1", 32'(grant_id),     32'd1);
        check("mp_rdy3",   32'(s_axis_ready[3]), 32'd0);
        tick();
        set_src(1, 1'b0, 1'b0, 8'h00);
        #1;
        check("mp_idle_vld", 32'(m_axis_valid), 32'd0);
        check("mp_idle_rdy", 32'(s_axis_ready), 32'h0);
        tick();
        check("mp_hdr3", 32'(m_axis_data), 32'hA3);
        tick();
        check("mp_s3",      32'(m_axis_data), 32'h3F);
        check("mp_s3_last", 32'(m_axis_last), 32'd1);
        tick();
        set_src(3, 1'b0, 1'b0, 8'h00);

        // ---- backpressure: ready toggles during a 4-beat src0 packet (rr_ptr is 0 here)
        exp_beats[0] = 8'hA0;
        exp_beats[1] = 8'h41;
        exp_beats[2] = 8'h42;
        exp_beats[3] = 8'h43;
        exp_beats[4] = 8'h44;
        k       = 0;
        src_idx = 0;
        cyc     = 0;
        while (k < 5 && cyc < 40) begin
            set_src(0, src_idx < 4, src_idx == 3, 8'(8'h41 + src_idx));
            m_axis_ready = cyc[0];
            #1;
            if (m_axis_valid) begin
                check($sformatf("bp_dat_%0d", k),  32'(m_axis_data), 32'(exp_beats[k]));
                check($sformatf("bp_last_%0d", k), 32'(m_axis_last), 32'(k == 4));
            end
            xfer = m_axis_valid && m_axis_ready;
            tick();
            if (xfer) begin
                if (k > 0) src_idx++;
                k++;
            end
            cyc++;
        end
        set_src(0, 1'b0, 1'b0, 8'h00);
        m_axis_ready = 1'b1;
        #1;
        check("bp_beats",   32'(k),       32'd5);
        check("bp_src_cnt", 32'(src_idx), 32'd4);
        check("bp_busy",    32'(busy),    32'd0);

        // ---- reset after beat 2 of a 4-beat src2 packet (rr_ptr is 1 here)
        set_src(2, 1'b1, 1'b0, 8'h51);
        tick();
        check("rm_hdr2", 32'(m_axis_data), 32'hA2);
        tick();
        check("rm_b0", 32'(m_axis_data), 32'h51);
        tick();
        set_src(2, 1'b1, 1'b0, 8'h52);
        #1;
        check("rm_b1", 32'(m_axis_data), 32'h52);
        tick();
        set_src(2, 1'b1, 1'b0, 8'h53);
        rst = 1'b1;
        #1;
        check_quiet("rm_during");
        tick();
        rst = 1'b0;
        set_src(0, 1'b1, 1'b1, 8'h61);
        #1;
        check_quiet("rm_after");
        check("rm_grant_rst", 32'(grant_id), 32'd0);
        tick();
        check("rm_grant0", 32'(grant_id),    32'd0);
        check("rm_hdr0",   32'(m_axis_data), 32'hA0);
        set_src(0, 1'b0, 1'b0, 8'h00);
        set_src(2, 1'b0, 1'b0, 8'h00);

        // ---- headerless build: src1 packet 5,6
        do_reset();
        set_b(1, 1'b1, 1'b0, 8'h05);
        #1;
        check("nh_idle_vld", 32'(bm_valid), 32'd0);
        tick();
        check("nh_b0_vld",  32'(bm_valid), 32'd1);
        check("nh_b0_dat",  32'(bm_data),  32'h05);
        check("nh_grant",   32'(b_grant),  32'd1);
        check("nh_b0_rdy",  32'(b_ready),  32'h2);
        check("nh_b0_last", 32'(bm_last),  32'd0);
        tick();
        set_b(1, 1'b1, 1'b1, 8'h06);
        #1;
        check("nh_b1_dat",  32'(bm_data), 32'h06);
        check("nh_b1_last", 32'(bm_last), 32'd1);
        tick();
        set_b(1, 1'b0, 1'b0, 8'h00);
        #1;
        check("nh_end_busy", 32'(b_busy),   32'd0);
        check("nh_end_vld",  32'(bm_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/axis_uart_tx_arbiter.md
AXIS_UART_TX_ARBITER -- requirements
Module: axis_uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of AXI-Stream requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, data width per beat.
REQ-003 SHALL have parameter HDR_EN, default 1, enabling insertion of a one-beat source-ID header per packet.
REQ-004 SHALL have parameter HDR_BASE, default 8'hA0, header constant OR-ed with the granted source index.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port s_axis_data, input, NUM_SRC*WIDTH, packed per-source data; source i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have ports s_axis_valid, s_axis_last, input, NUM_SRC each, and s_axis_ready, output, NUM_SRC, per-source handshake.
REQ-009 SHALL have ports m_axis_data (output, WIDTH), m_axis_valid (output, 1), m_axis_last (output, 1) and m_axis_ready (input, 1) toward the downstream FIFO/UART transmitter.
REQ-010 SHALL have port grant_id, output, clog2(NUM_SRC), index of the current owner, and port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, HDR and DATA.
REQ-012 IDLE: if any s_axis_valid is high, SHALL latch the round-robin winner into grant_id; the next state is HDR when HDR_EN=1, otherwise DATA.
REQ-013 Round-robin SHALL search from index rr_ptr upward with wrap-around; the first source with valid high wins.
REQ-014 HDR: SHALL drive m_axis_valid=1, m_axis_last=0 and m_axis_data=HDR_BASE|grant_id; on m_axis_ready=1 the FSM SHALL go to DATA.
REQ-015 DATA: m_axis_data, m_axis_valid and m_axis_last SHALL be combinational copies of the granted source, and s_axis_ready[grant_id] SHALL equal m_axis_ready.
REQ-016 A beat with m_axis_valid, m_axis_ready and m_axis_last all high in DATA SHALL return the FSM to IDLE and set rr_ptr to grant_id+1 modulo NUM_SRC.
REQ-017 Non-granted s_axis_ready bits SHALL be 0 at all times, and all s_axis_ready bits SHALL be 0 in IDLE and HDR.
REQ-018 The grant SHALL NOT change mid-packet regardless of other sources' valid.
REQ-019 Arbitration latency SHALL be exactly one cycle in IDLE: the header or first data beat is presented the cycle after the grant is latched.
REQ-020 A source deasserting valid mid-packet SHALL keep the grant; m_axis_valid follows it low.
REQ-021 m_axis_valid SHALL be 0 in IDLE; a downstream stall (m_axis_ready=0) SHALL hold HDR/DATA with output stable.
REQ-022 HDR_BASE|grant_id SHALL be truncated to WIDTH bits.

Reset
REQ-023 On rst=1 at a clock edge, state SHALL go to IDLE, rr_ptr=0, grant_id=0.
REQ-024 During and after reset, outputs SHALL be m_axis_valid=0, m_axis_last=0, m_axis_data=0, s_axis_ready=0 and busy=0.
REQ-025 Reset mid-packet SHALL abandon the packet without emitting m_axis_last; the remainder of the abandoned packet is re-arbitrated as a new packet.

Structure
REQ-026 State encoding and the header constant SHALL live in a shared package, with the round-robin search as sub-module rr_pick (inputs req and ptr; output idx and any).
REQ-027 The block SHALL instantiate cleanly upstream of axis_fifo_uart_tx, with m_axis_* connected to its s_axis_* ports.

Verification
REQ-028 Single source: src1 sends 3 bytes 11,22,33 (last on 33) with HDR_EN=1 -> out A1,11,22,33, last only on 33, then busy=0.
REQ-029 Contention: src0 and src2 each hold a 2-beat packet from reset -> order A0,src0,src0,A2,src2,src2; then a new src0 packet follows src2.
REQ-030 Mid-packet request: src3 raises valid during a src1 packet -> no src3 beat until src1 last is accepted; s_axis_ready[3]=0 throughout.
REQ-031 Backpressure: m_axis_ready toggles 1/0 every cycle during a 4-beat packet -> every beat is transferred exactly once, with data stable while stalled.
REQ-032 Reset mid-packet: rst is pulsed after beat 2 of a 4-beat src2 packet -> all outputs are 0 the next cycle, and rr_ptr=0 so src0 wins the next contention with src2.
REQ-033 HDR_EN=0: a src1 packet of 5,6 -> out 5,6 with no header beat, first beat presented one cycle after the grant is latched.
